// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART transmit arbiter
//                slice: the arbiter state encoding, the default byte width
//                and an index-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default byte width handed to the UART transmitter.
    localparam int c_data_w_default = 8;

    // Arbiter sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_NEXT      = 3'd4,
        ST_HOLD      = 3'd5
    } arb_state_e;

    // Width of an index into an n-entry vector. A single entry still needs
    // one bit so that ports never become zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter_if
//  Description : Bundle of the requester byte-stream handshake and the UART
//                transmitter control signals around the transmit arbiter.
//                master = producer/transmitter side, slave = arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    import uart_pkg::*;

    localparam int ID_W = idx_width(NUM_REQ);

    // Requester side
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;

    // UART transmitter side
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_start;
    logic                      tx_busy;

    // Status
    logic [ID_W-1:0]           grant_id;
    logic                      locked;
    logic                      ack_err;

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_data, tx_start, grant_id, locked, ack_err
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_data, tx_start, grant_id, locked, ack_err
    );

endinterface : uart_tx_arbiter_if
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin priority picker. Returns the first
//                set request at or above the pointer, wrapping past the top
//                index, as both a one-hot grant and a binary index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic [N-1:0]     i_req,
    input  wire logic [IDX_W-1:0] i_ptr,
    output logic      [N-1:0]     o_gnt,
    output logic      [IDX_W-1:0] o_idx,
    output logic                  o_any
);

    // One spare bit so that j + N - ptr never overflows.
    localparam logic [IDX_W:0] c_n = (IDX_W + 1)'(N);

    // Pick the request with the smallest wrapped distance from the pointer.
    always_comb begin : p_pick
        logic [IDX_W:0] w_best;
        logic [IDX_W:0] w_dist;
        logic [IDX_W:0] w_j;
        logic [IDX_W:0] w_ptr;
        logic [IDX_W-1:0] w_idx;

        w_best = c_n;
        w_dist = '0;
        w_j    = '0;
        w_ptr  = {1'b0, i_ptr};
        w_idx  = '0;

        for (int j = 0; j < N; j++) begin
            w_j = (IDX_W + 1)'(j);
            if (w_j >= w_ptr) begin
                w_dist = w_j - w_ptr;
            end else begin
                w_dist = w_j + c_n - w_ptr;
            end
            if (i_req[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_idx  = IDX_W'(j);
            end
        end

        o_any = |i_req;
        o_idx = w_idx;
        o_gnt = '0;
        for (int j = 0; j < N; j++) begin
            o_gnt[j] = o_any && (w_idx == IDX_W'(j));
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares one UART transmitter between NUM_REQ byte-stream
//                requesters. Round-robin arbitration between packets, with the
//                grant locked to one requester until its last byte. Each byte
//                is launched with a one-cycle tx_start and retired by watching
//                tx_busy rise and fall; a start that never raises tx_busy is
//                abandoned after ACK_TIMEOUT cycles with an ack_err pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = c_data_w_default,
    parameter int ACK_TIMEOUT = 16
) (
    input  wire logic clk,
    input  wire logic rstn,
    uart_tx_arbiter_if.slave bus
);

    localparam int ID_W  = idx_width(NUM_REQ);
    localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

    // The counter is checked one step early so that ack_err, being
    // registered, appears in the cycle the count reaches ACK_TIMEOUT-1.
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(ACK_TIMEOUT - 2);
    localparam logic [ID_W-1:0]  c_id_max   = ID_W'(NUM_REQ - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_e        state_q,    state_d;
    logic [ID_W-1:0]   ptr_q,      ptr_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [DATA_W-1:0] tx_data_q,  tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              locked_q,   locked_d;
    logic              ack_err_q,  ack_err_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;

    logic [NUM_REQ-1:0] w_req_ready;
    logic [NUM_REQ-1:0] w_pick_gnt;
    logic [ID_W-1:0]    w_pick_idx;
    logic               w_pick_any;
    logic [DATA_W-1:0]  w_req_bytes [NUM_REQ];

    // ------------------------------------------------------------------
    // Split the packed request bus into one byte per requester
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_req_bytes[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    end

    // ------------------------------------------------------------------
    // Round-robin winner among all valid requesters
    // ------------------------------------------------------------------
    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_rr_pick (
        .i_req (bus.req_valid),
        .i_ptr (ptr_q),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // Next-state and accept decode for the byte sequencer.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_id_d  = grant_id_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        locked_d    = locked_q;
        ack_err_d   = 1'b0;
        cnt_d       = cnt_q;
        w_req_ready = '0;

        case (state_q)
            ST_IDLE: begin
                // A new packet may only start when the transmitter is free.
                if (!locked_q && !bus.tx_busy && w_pick_any) begin
                    w_req_ready = w_pick_gnt;
                    tx_data_d   = w_req_bytes[w_pick_idx];
                    grant_id_d  = w_pick_idx;
                    locked_d    = !bus.req_last[w_pick_idx];
                    tx_start_d  = 1'b1;
                    state_d     = ST_START;
                end
            end

            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT_ACK;
            end

            ST_WAIT_ACK: begin
                if (bus.tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // Lost start: give up on this byte and move on as if sent.
                    if (cnt_q == c_cnt_last) begin
                        ack_err_d = 1'b1;
                        state_d   = ST_NEXT;
                    end
                end
            end

            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = ST_NEXT;
                end
            end

            ST_NEXT: begin
                if (locked_q) begin
                    state_d = ST_HOLD;
                end else begin
                    // Packet finished: the requester after it gets first pick.
                    ptr_d   = (grant_id_q == c_id_max) ? '0 : grant_id_q + ID_W'(1);
                    state_d = ST_IDLE;
                end
            end

            ST_HOLD: begin
                // Mid-packet: only the owner of the lock may deliver a byte.
                if (bus.req_valid[grant_id_q] && !bus.tx_busy) begin
                    w_req_ready[grant_id_q] = 1'b1;
                    tx_data_d  = w_req_bytes[grant_id_q];
                    locked_d   = !bus.req_last[grant_id_q];
                    tx_start_d = 1'b1;
                    state_d    = ST_START;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers; reset abandons any byte in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            grant_id_q <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            locked_q   <= 1'b0;
            ack_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            locked_q   <= locked_d;
            ack_err_q  <= ack_err_d;
            cnt_q      <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. req_ready is the only combinational output; it is forced
    // low while reset is asserted so no byte can be accepted then.
    // ------------------------------------------------------------------
    assign bus.req_ready = rstn ? w_req_ready : '0;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.locked    = locked_q;
    assign bus.ack_err   = ack_err_q;

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Self-checking bench for uart_tx_arbiter. Per-requester byte
//                queues model the producers, a small model plays the UART
//                transmitter busy flag, and a scoreboard holds the expected
//                order of transmitted bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;

    localparam int BM_AUTO = 0;   // busy rises 1 cycle after start, 10 cycles long
    localparam int BM_LOW  = 1;   // transmitter never answers
    localparam int BM_HIGH = 2;   // transmitter stuck busy

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ     (NR),
        .DATA_W      (DW),
        .ACK_TIMEOUT (16)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] id;
        logic       lck;
    } exp_t;

    typedef struct packed {
        logic [3:0]      mask;
        logic            rep0;
        logic [2:0]      n;
        logic [4:0][1:0] order;
        logic [3:0][7:0] data;
    } vec_t;

    exp_t exp_q[$];
    vec_t vt[5];

    int checks   = 0;
    int failures = 0;
    int cyc = 0;
    int start_cnt = 0;
    int ack_cnt = 0;
    int ready_cnt = 0;
    int last_start_cyc = 0;
    int ack_cyc = 0;

    logic [8:0] pbuf [4][16];
    int head [4];
    int tail [4];
    logic [3:0] acc = '0;
    logic [3:0] prev_ready = '0;
    int bmode = BM_AUTO;
    int pend = 0;
    int bleft = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push_byte(input int r, input logic [7:0] d, input logic last);
        pbuf[r][tail[r] % 16] = {last, d};
        tail[r]++;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic [1:0] id, input logic l);
        exp_t e;
        e.data = d;
        e.id   = id;
        e.lck  = l;
        exp_q.push_back(e);
    endtask

    function automatic bit bytes_pending();
        for (int i = 0; i < NR; i++) begin
            if (head[i] != tail[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock: drive after the rising edge, observe on the falling edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) head[i]++;
        end
        if (bmode == BM_AUTO) begin
            if (bleft > 0) begin
                bleft--;
                bus.tx_busy = (bleft > 0);
            end else if (pend != 0) begin
                bus.tx_busy = 1'b1;
                bleft = 10;
                pend = 0;
            end else begin
                bus.tx_busy = 1'b0;
            end
            if (bus.tx_start) pend = 1;
        end else begin
            pend = 0;
            bleft = 0;
            bus.tx_busy = (bmode == BM_HIGH);
        end
        for (int i = 0; i < NR; i++) begin
            if (head[i] != tail[i]) begin
                bus.req_valid[i]      = 1'b1;
                bus.req_data[i*DW +: DW] = pbuf[i][head[i] % 16][7:0];
                bus.req_last[i]       = pbuf[i][head[i] % 16][8];
            end else begin
                bus.req_valid[i]      = 1'b0;
                bus.req_data[i*DW +: DW] = '0;
                bus.req_last[i]       = 1'b0;
            end
        end

        @(negedge clk);
        cyc++;
        if (bus.tx_start) begin
            start_cnt++;
            last_start_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL tx_start_unexpected actual=1 expected=0 data=%0h (cycle %0d)", bus.tx_data, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("tx_data", bus.tx_data, e.data);
                chk("grant_id", bus.grant_id, e.id);
                chk("locked_at_start", bus.locked, e.lck);
            end
        end
        if (bus.req_ready != '0) begin
            ready_cnt++;
            chk("ready_onehot", $onehot(bus.req_ready), 1);
            chk("ready_pulse", bus.req_ready & prev_ready, 0);
        end
        prev_ready = bus.req_ready;
        if (bus.ack_err) begin
            ack_cnt++;
            ack_cyc = cyc;
        end
        acc = bus.req_valid & bus.req_ready;
    endtask

    // Run until the scoreboard and producers are empty, then let the frame end.
    task automatic drain(input int budget, input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bytes_pending()) && n < budget) begin
            tick();
            n++;
        end
        chk({"drain_", tag}, exp_q.size(), 0);
        exp_q.delete();
        repeat (16) tick();
    endtask

    task automatic wait_start(input int budget, input string tag);
        int s0;
        int n;
        s0 = start_cnt;
        n = 0;
        while (start_cnt == s0 && n < budget) begin
            tick();
            n++;
        end
        chk({"start_seen_", tag}, start_cnt - s0, 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 0);
        chk({tag, "_tx_start"},  bus.tx_start, 0);
        chk({tag, "_tx_data"},   bus.tx_data, 0);
        chk({tag, "_grant_id"},  bus.grant_id, 0);
        chk({tag, "_locked"},    bus.locked, 0);
        chk({tag, "_ack_err"},   bus.ack_err, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int r0;
        int a0;
        logic [1:0] id;

        // mask, rep0, n, order {o4..o0}, data {d3..d0}
        vt[0] = '{mask:4'b1111, rep0:1'b1, n:3'd5, order:{2'd0, 2'd3, 2'd2, 2'd1, 2'd0},
                  data:{8'h13, 8'h12, 8'h11, 8'h10}};
        vt[1] = '{mask:4'b0001, rep0:1'b0, n:3'd1, order:{2'd0, 2'd0, 2'd0, 2'd0, 2'd0},
                  data:{8'h00, 8'h00, 8'h00, 8'hA5}};
        vt[2] = '{mask:4'b1010, rep0:1'b0, n:3'd2, order:{2'd0, 2'd0, 2'd0, 2'd3, 2'd1},
                  data:{8'h23, 8'h00, 8'h21, 8'h00}};
        vt[3] = '{mask:4'b0110, rep0:1'b0, n:3'd2, order:{2'd0, 2'd0, 2'd0, 2'd2, 2'd1},
                  data:{8'h00, 8'h32, 8'h31, 8'h00}};
        vt[4] = '{mask:4'b1001, rep0:1'b0, n:3'd2, order:{2'd0, 2'd0, 2'd0, 2'd0, 2'd3},
                  data:{8'h43, 8'h00, 8'h00, 8'h40}};

        for (int i = 0; i < NR; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        rstn          = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_busy   = 1'b0;

        // Reset state
        repeat (3) tick();
        check_zero("reset");
        rstn = 1'b1;
        tick();

        // Single-byte packets: RR order and pointer advance
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < NR; i++) begin
                if (vt[r].mask[i]) push_byte(i, vt[r].data[i], 1'b1);
            end
            if (vt[r].rep0) push_byte(0, vt[r].data[0], 1'b1);
            for (int k = 0; k < 5; k++) begin
                if (k < int'(vt[r].n)) begin
                    id = vt[r].order[k];
                    push_exp(vt[r].data[id], id, 1'b0);
                end
            end
            s0 = start_cnt;
            drain(300, "row");
            chk("row_starts", start_cnt - s0, 32'(vt[r].n));
            chk("row_unlocked", bus.locked, 0);
        end

        // Packet lock: req1 three bytes must beat the waiting req2
        push_byte(1, 8'h01, 1'b0);
        push_byte(1, 8'h02, 1'b0);
        push_byte(1, 8'h03, 1'b1);
        push_byte(2, 8'h52, 1'b1);
        push_exp(8'h01, 2'd1, 1'b1);
        push_exp(8'h02, 2'd1, 1'b1);
        push_exp(8'h03, 2'd1, 1'b0);
        push_exp(8'h52, 2'd2, 1'b0);
        drain(300, "packet");

        // Lost start: ack_err 16 cycles after tx_start, then arbitration resumes
        bmode = BM_LOW;
        push_byte(2, 8'h77, 1'b1);
        push_exp(8'h77, 2'd2, 1'b0);
        a0 = ack_cnt;
        wait_start(40, "timeout");
        repeat (20) tick();
        chk("ack_count", ack_cnt - a0, 1);
        chk("ack_delay", ack_cyc - last_start_cyc, 16);
        bmode = BM_AUTO;
        push_byte(0, 8'h88, 1'b1);
        push_exp(8'h88, 2'd0, 1'b0);
        drain(100, "after_timeout");
        chk("ack_once", ack_cnt - a0, 1);

        // Busy gating: no accept while the transmitter is busy
        bmode = BM_HIGH;
        push_byte(2, 8'h99, 1'b1);
        push_exp(8'h99, 2'd2, 1'b0);
        s0 = start_cnt;
        r0 = ready_cnt;
        repeat (8) tick();
        chk("gate_no_start", start_cnt - s0, 0);
        chk("gate_no_ready", ready_cnt - r0, 0);
        bmode = BM_AUTO;
        drain(100, "gate");
        chk("gate_one_start", start_cnt - s0, 1);

        // Reset in the middle of a locked packet
        push_byte(3, 8'hE1, 1'b0);
        push_byte(3, 8'hE2, 1'b1);
        push_exp(8'hE1, 2'd3, 1'b1);
        push_exp(8'hE2, 2'd3, 1'b0);
        wait_start(40, "midframe");
        repeat (4) tick();
        chk("pre_reset_locked", bus.locked, 1);
        #2;
        rstn = 1'b0;
        #1;
        check_zero("async_reset");
        for (int i = 0; i < NR; i++) head[i] = tail[i];
        exp_q.delete();
        acc = '0;
        prev_ready = '0;
        pend = 0;
        bleft = 0;
        bus.tx_busy = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        // Pointer back at 0: req1 ahead of req3
        push_byte(1, 8'hF1, 1'b1);
        push_byte(3, 8'hF3, 1'b1);
        push_exp(8'hF1, 2'd1, 1'b0);
        push_exp(8'hF3, 2'd3, 1'b0);
        drain(200, "post_reset");

        chk("total_ack", ack_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
